// File: rtl/piso_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_arbiter
// Brief    : Round-robin arbiter that feeds bytes from two requesters into an
//            external PISO; sequences LOAD, 8 SHIFT cycles and an optional gap.
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx_arbiter #(
    parameter int P_GAP = 0
) (
    input  logic       in_Clk,
    input  logic       in_Rst_n,
    input  logic       in_Enable,
    input  logic       in_Req0_Valid,
    input  logic [7:0] in_Req0_Data,
    input  logic       in_Req1_Valid,
    input  logic [7:0] in_Req1_Data,
    output logic       out_Ack0,
    output logic       out_Ack1,
    output logic       out_Load,
    output logic [7:0] out_PisoData,
    output logic       out_Frame,
    output logic       out_FrameSrc,
    output logic       out_Busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    localparam bit         c_NO_GAP   = (P_GAP == 0);
    localparam logic [3:0] c_GAP_LAST = (P_GAP > 0) ? 4'(P_GAP - 1) : 4'd0;

    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [2:0] r_bit_cnt;
    logic [3:0] r_gap_cnt;
    logic       r_prio1;
    logic [7:0] r_piso_data;
    logic       r_frame_src;
    logic       w_arb_point;
    logic       w_grant0;
    logic       w_grant1;

    // Assertion propagates asynchronously; release takes two clock edges.
    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // With no gap the next byte is granted on the last bit so frames abut.
    assign w_arb_point = w_rst_n && in_Enable &&
                         ((r_state == c_ST_IDLE) ||
                          (c_NO_GAP && (r_state == c_ST_SHIFT) && (r_bit_cnt == 3'd7)));
    assign w_grant0    = w_arb_point && in_Req0_Valid && (!in_Req1_Valid || !r_prio1);
    assign w_grant1    = w_arb_point && in_Req1_Valid && (!in_Req0_Valid || r_prio1);

    always_ff @(posedge in_Clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    w_next_state = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_next_state = c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                if (r_bit_cnt == 3'd7) begin
                    if (c_NO_GAP) begin
                        w_next_state = (w_grant0 || w_grant1) ? c_ST_LOAD : c_ST_IDLE;
                    end else begin
                        w_next_state = c_ST_GAP;
                    end
                end
            end
            c_ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_Clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_bit_cnt   <= 3'd0;
            r_gap_cnt   <= 4'd0;
            r_prio1     <= 1'b0;
            r_piso_data <= 8'h00;
            r_frame_src <= 1'b0;
        end else begin
            if (r_state == c_ST_LOAD) begin
                r_bit_cnt <= 3'd0;
            end else if (r_state == c_ST_SHIFT) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_state == c_ST_SHIFT) begin
                r_gap_cnt <= 4'd0;
            end else if (r_state == c_ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 4'd1;
            end
            // Priority swings to whichever requester did not just win.
            if (w_grant0 || w_grant1) begin
                r_piso_data <= w_grant1 ? in_Req1_Data : in_Req0_Data;
                r_frame_src <= w_grant1;
                r_prio1     <= w_grant0;
            end
        end
    end

    always_comb begin
        out_Ack0     = w_grant0;
        out_Ack1     = w_grant1;
        out_Load     = (r_state == c_ST_LOAD);
        out_Frame    = (r_state == c_ST_SHIFT);
        out_Busy     = (r_state != c_ST_IDLE);
        out_PisoData = r_piso_data;
        out_FrameSrc = r_frame_src;
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx_arbiter
// Brief    : Bench driving a P_GAP=0 and a P_GAP=3 instance against a
//            timeline-based reference model plus scenario-specific checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_piso_tx_arbiter;

    typedef logic [7:0] byte_q_t [$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       v     [2][2];
    logic [7:0] dat   [2][2];
    logic       ack0  [2];
    logic       ack1  [2];
    logic       load  [2];
    logic [7:0] pdat  [2];
    logic       frame [2];
    logic       src   [2];
    logic       busy  [2];
    logic [7:0] piso  [2];

    byte_q_t    q [2][2];
    bit         hold_off [2];
    int         cyc = 0;
    int         rel_edges = 0;
    int         checks = 0;
    int         errors = 0;

    bit         m_has   [2];
    int         m_t     [2];
    bit         m_prio1 [2];
    logic [7:0] m_data  [2];
    bit         m_src   [2];
    bit         mg0     [2];
    bit         mg1     [2];
    logic [14:0] exp_v  [2];
    logic [14:0] obs_v  [2];
    bit          glog [$];
    int          gcyc [$];

    always #5 clk = ~clk;

    piso_tx_arbiter #(.P_GAP(0)) u_dut_g0 (
        .in_Clk(clk), .in_Rst_n(rst_n), .in_Enable(en),
        .in_Req0_Valid(v[0][0]), .in_Req0_Data(dat[0][0]),
        .in_Req1_Valid(v[0][1]), .in_Req1_Data(dat[0][1]),
        .out_Ack0(ack0[0]), .out_Ack1(ack1[0]), .out_Load(load[0]),
        .out_PisoData(pdat[0]), .out_Frame(frame[0]), .out_FrameSrc(src[0]),
        .out_Busy(busy[0])
    );

    piso_tx_arbiter #(.P_GAP(3)) u_dut_g3 (
        .in_Clk(clk), .in_Rst_n(rst_n), .in_Enable(en),
        .in_Req0_Valid(v[1][0]), .in_Req0_Data(dat[1][0]),
        .in_Req1_Valid(v[1][1]), .in_Req1_Data(dat[1][1]),
        .out_Ack0(ack0[1]), .out_Ack1(ack1[1]), .out_Load(load[1]),
        .out_PisoData(pdat[1]), .out_Frame(frame[1]), .out_FrameSrc(src[1]),
        .out_Busy(busy[1])
    );

    // External PISO: load when Load is high, otherwise shift right (LSB out).
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            piso[d] <= load[d] ? pdat[d] : {1'b0, piso[d][7:1]};
        end
    end

    task automatic push_both(input int r, input logic [7:0] b);
        for (int d = 0; d < 2; d++) q[d][r].push_back(b);
    endtask

    task automatic clear_queues();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 2; r++) q[d][r].delete();
    endtask

    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 2; r++) begin
                if (q[d][r].size() > 0) begin
                    v[d][r]   = !hold_off[r];
                    dat[d][r] = q[d][r][0];
                end else begin
                    v[d][r]   = 1'b0;
                    dat[d][r] = 8'($urandom);
                end
            end
        end
    endtask

    // Frame timeline model: a grant at cycle t owns t+1 (load), t+2..t+9
    // (bits), then P_GAP idle cycles; the next grant may occur from t+9
    // (no gap) or once the gap has elapsed and one idle cycle is reached.
    task automatic model_eval();
        int  gap;
        int  k;
        bit  arb, ld, fr, bz, sb;
        for (int d = 0; d < 2; d++) begin
            gap = (d == 0) ? 0 : 3;
            mg0[d] = 1'b0;
            mg1[d] = 1'b0;
            if (!rst_n) begin
                exp_v[d] = '0;
                obs_v[d] = {ack0[d], ack1[d], load[d], frame[d], busy[d], src[d], 1'b0, pdat[d]};
            end else begin
                arb = (rel_edges >= 2) && en &&
                      (!m_has[d] || (cyc >= m_t[d] + ((gap == 0) ? 9 : 10 + gap)));
                mg0[d] = arb && v[d][0] && (!v[d][1] || !m_prio1[d]);
                mg1[d] = arb && v[d][1] && (!v[d][0] ||  m_prio1[d]);
                k  = cyc - m_t[d];
                ld = m_has[d] && (k == 1);
                fr = m_has[d] && (k >= 2) && (k <= 9);
                bz = m_has[d] && (k >= 1) && (k <= 9 + gap);
                sb = 1'b0;
                if (fr) sb = m_data[d][k-2];
                exp_v[d] = {mg0[d], mg1[d], ld, fr, bz, m_src[d], sb, m_data[d]};
                obs_v[d] = {ack0[d], ack1[d], load[d], frame[d], busy[d], src[d],
                            fr ? piso[d][0] : 1'b0, pdat[d]};
            end
        end
    endtask

    task automatic model_commit();
        int w;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_has[d] = 1'b0; m_prio1[d] = 1'b0; m_data[d] = 8'h00; m_src[d] = 1'b0;
            end else if (mg0[d] || mg1[d]) begin
                w = mg1[d] ? 1 : 0;
                m_has[d]   = 1'b1;
                m_t[d]     = cyc;
                m_src[d]   = mg1[d];
                m_data[d]  = dat[d][w];
                m_prio1[d] = mg0[d];
                void'(q[d][w].pop_front());
                if (d == 0) begin
                    glog.push_back(mg1[d]);
                    gcyc.push_back(cyc);
                end
            end
        end
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        cyc++;
        if (!rst_n) rel_edges = 0;
        else if (rel_edges < 2) rel_edges++;
        #1;
    endtask

    task automatic test_reset();
        int rc = -100;
        int ta = -100;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                rst_n = 1'b1;
                rc = cyc;
                push_both(0, 8'h11);
            end
            drive();
            @(negedge clk);
            model_eval();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_v[d] !== exp_v[d]) begin
                    errors++;
                    $display("FAIL reset dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_v[d], exp_v[d]);
                end
            end
            if (ack0[0] && ta < 0) ta = cyc;
            advance();
        end
        checks++;
        if (ta !== rc + 2) begin
            errors++;
            $display("FAIL reset_release_latency got=%0d exp=%0d", ta - rc, 2);
        end
    endtask

    task automatic test_single_byte();
        int ta = -100, tl = -100, nf = 0;
        logic [7:0] ser = 8'h00;
        logic busy_after = 1'b1;
        push_both(0, 8'hA5);
        for (int i = 0; i < 14; i++) begin
            drive();
            @(negedge clk);
            model_eval();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_v[d] !== exp_v[d]) begin
                    errors++;
                    $display("FAIL single_byte dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_v[d], exp_v[d]);
                end
            end
            if (ack0[0] && ta < 0) ta = cyc;
            if (load[0]) tl = cyc;
            if (frame[0]) begin
                ser = {piso[0][0], ser[7:1]};
                nf++;
            end
            if (cyc == ta + 10) busy_after = busy[0];
            advance();
        end
        checks++;
        if (tl !== ta + 1 || nf != 8 || ser !== 8'hA5 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL single_byte_timeline got load_dly=%0d bits=%0d ser=%h busy=%b exp 1/8/a5/0",
                     tl - ta, nf, ser, busy_after);
        end
    endtask

    task automatic test_contention();
        glog.delete();
        gcyc.delete();
        for (int i = 0; i < 30; i++) begin
            if (i == 0) begin
                rst_n = 1'b0;
                clear_queues();
            end
            if (i == 2) begin
                rst_n = 1'b1;
                push_both(0, 8'h0F);
                push_both(1, 8'hF0);
            end
            drive();
            @(negedge clk);
            model_eval();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_v[d] !== exp_v[d]) begin
                    errors++;
                    $display("FAIL contention dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_v[d], exp_v[d]);
                end
            end
            advance();
        end
        checks++;
        if (glog.size() != 2 || glog[0] != 1'b0 || glog[1] != 1'b1 || gcyc[1] - gcyc[0] != 9) begin
            errors++;
            $display("FAIL contention_order got n=%0d first=%0d second=%0d spacing=%0d exp 2/0/1/9",
                     glog.size(), glog[0], glog[1], gcyc[1] - gcyc[0]);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        glog.delete();
        gcyc.delete();
        for (int i = 0; i < 120; i++) begin
            if (i == 0) begin
                rst_n = 1'b0;
                clear_queues();
            end
            if (i == 2) begin
                rst_n = 1'b1;
                for (int n = 0; n < 4; n++) begin
                    push_both(0, 8'($urandom));
                    push_both(1, 8'($urandom));
                end
            end
            drive();
            @(negedge clk);
            model_eval();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_v[d] !== exp_v[d]) begin
                    errors++;
                    $display("FAIL fairness dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_v[d], exp_v[d]);
                end
            end
            advance();
        end
        ok = (glog.size() == 8);
        for (int n = 0; n < 8 && n < glog.size(); n++) begin
            if (glog[n] != n[0]) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fairness_order got %0d grants, not alternating 0,1,0,1.. exp 8 alternating",
                     glog.size());
        end
    endtask

    task automatic test_gap();
        int last_fr = -100;
        int delta = -1;
        push_both(0, 8'($urandom));
        push_both(0, 8'($urandom));
        for (int i = 0; i < 30; i++) begin
            drive();
            @(negedge clk);
            model_eval();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_v[d] !== exp_v[d]) begin
                    errors++;
                    $display("FAIL gap dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_v[d], exp_v[d]);
                end
            end
            if (ack0[1] && last_fr >= 0 && delta < 0) delta = cyc - last_fr;
            if (frame[1]) last_fr = cyc;
            advance();
        end
        checks++;
        if (delta != 4) begin
            errors++;
            $display("FAIL gap_spacing last_bit_to_ack got=%0d exp=%0d", delta, 4);
        end
    endtask

    task automatic test_enable();
        bit dropped = 1'b0;
        int drop_cyc = -100, rise_cyc = -100, ack_after = -100;
        int acks_low = 0, nf = 0;
        en = 1'b1;
        push_both(0, 8'($urandom));
        push_both(0, 8'($urandom));
        for (int i = 0; i < 44; i++) begin
            if (!dropped && m_has[0] && cyc == m_t[0] + 5) begin
                en = 1'b0;
                dropped = 1'b1;
                drop_cyc = cyc;
            end
            if (dropped && cyc == drop_cyc + 10) begin
                en = 1'b1;
                rise_cyc = cyc;
            end
            drive();
            @(negedge clk);
            model_eval();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_v[d] !== exp_v[d]) begin
                    errors++;
                    $display("FAIL enable dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_v[d], exp_v[d]);
                end
            end
            if (!en && (ack0[0] || ack1[0] || ack0[1] || ack1[1])) acks_low++;
            if (rise_cyc >= 0 && ack0[0] && ack_after < 0) ack_after = cyc;
            if (frame[0]) nf++;
            advance();
        end
        checks++;
        if (acks_low != 0 || ack_after != rise_cyc || nf != 16) begin
            errors++;
            $display("FAIL enable_behaviour got acks_low=%0d resume_dly=%0d bits=%0d exp 0/0/16",
                     acks_low, ack_after - rise_cyc, nf);
        end
    endtask

    task automatic test_reset_midframe();
        bit done = 1'b0;
        int rst_cyc = -100, nf = 0;
        logic [7:0] ser = 8'h00;
        logic [12:0] imm;
        push_both(0, 8'h5A);
        for (int i = 0; i < 40; i++) begin
            if (!done && m_has[0] && cyc == m_t[0] + 6) begin
                #2;
                rst_n = 1'b0;
                #1;
                done = 1'b1;
                rst_cyc = cyc;
                clear_queues();
                for (int d = 0; d < 2; d++) begin
                    imm = {ack0[d], ack1[d], load[d], frame[d], busy[d], src[d], pdat[d]};
                    checks++;
                    if (imm !== 13'd0) begin
                        errors++;
                        $display("FAIL reset_immediate dut%0d got=%h exp=%h", d, imm, 13'd0);
                    end
                end
            end
            if (done && cyc == rst_cyc + 3) begin
                rst_n = 1'b1;
                push_both(1, 8'h3C);
            end
            drive();
            @(negedge clk);
            model_eval();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_v[d] !== exp_v[d]) begin
                    errors++;
                    $display("FAIL reset_mid dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_v[d], exp_v[d]);
                end
            end
            if (done && frame[0]) begin
                ser = {piso[0][0], ser[7:1]};
                nf++;
            end
            advance();
        end
        checks++;
        if (!done || nf != 8 || ser !== 8'h3C) begin
            errors++;
            $display("FAIL reset_mid_frame got bits=%0d ser=%h exp 8/3c", nf, ser);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (q[0][r].size() < 3 && ($urandom % 4) == 0) push_both(r, 8'($urandom));
                hold_off[r] = (($urandom % 5) == 0);
            end
            en = (($urandom % 8) != 0);
            drive();
            @(negedge clk);
            model_eval();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_v[d] !== exp_v[d]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", d, cyc, obs_v[d], exp_v[d]);
                end
            end
            advance();
        end
        hold_off[0] = 1'b0;
        hold_off[1] = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        hold_off[0] = 1'b0;
        hold_off[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_has[d] = 1'b0; m_t[d] = 0; m_prio1[d] = 1'b0; m_data[d] = 8'h00; m_src[d] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                v[d][r] = 1'b0;
                dat[d][r] = 8'h00;
            end
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_contention();
        test_fairness();
        test_gap();
        test_enable();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
